alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Logic ops and add/sub/compare complete in one cycle.
- Unsigned multiply and unsigned divide/remainder run iteratively over WIDTH cycles.
- Sits between the operand-fetch stage and writeback. Valid/ready handshakes on both sides let the pipeline stall on long operations.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- oper  in  4  opcode (isa_def.v ALU_* codes).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Y  out  WIDTH  primary result.
- Y_hi  out  WIDTH  MUL: product high half; DIVU: remainder; else 0.
- N, Z, C, V  out  1 each  flags.
- busy  out  1  iterative operation in progress.

Behaviour:
- Clock/reset: one clock `clk`. `rst_n` is asynchronous, active-low.
- Reset: state=IDLE; in_ready=1; out_valid=0; Y, Y_hi, N, Z, C, V = 0; busy=0; counter=0.
- Reset mid-operation: any state returns to IDLE immediately; the in-flight operation is discarded; no out_valid is produced.
- FSM states: IDLE, MUL_IT, DIV_IT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready. On accept, a, b and oper are latched; later changes on the inputs are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, CMP, unknown):
  - Result and flags registered on the accept edge; state→DONE.
  - out_valid high the following cycle (latency 1).
- MUL: state→MUL_IT. Shift-add loop, one bit per cycle, WIDTH cycles, then DONE. Latency WIDTH+1.
- DIVU: state→DIV_IT. Restoring divider, one quotient bit per cycle, WIDTH cycles, then DONE. Latency WIDTH+1.
- busy=1 in MUL_IT and DIV_IT only.
- DONE:
  - out_valid=1. Y, Y_hi and flags are held stable until out_ready.
  - out_ready & in_valid in the same cycle: the new op is accepted (back-to-back, no bubble).
  - out_ready & !in_valid: state→IDLE.
- After the out_valid/out_ready transfer, outputs keep their last value; only out_valid drops.
- Flags, ADD: C = carry out of bit WIDTH-1; V = signed overflow; N = Y[WIDTH-1]; Z = (Y==0).
- Flags, SUB/CMP: Y = a-b (CMP drives Y=0 but flags from a-b); C = 1 when a≥b unsigned (no borrow); V = signed overflow; N and Z from a-b.
- Flags, AND/OR/XOR/NOT: N = Y msb, Z = (Y==0), C=0, V=0.
- Flags, MUL: {Y_hi,Y} = a*b unsigned.
  - Z = full 2·WIDTH product == 0.
  - N = Y[WIDTH-1].
  - C = |Y_hi.
  - V = (Y_hi != replicated Y[WIDTH-1]).
- Flags, DIVU: Y = a/b, Y_hi = a%b. N = Y msb, Z = (Y==0), C=0, V=0.
- Divide by zero (b==0 on DIVU): no iteration; treated as a single-cycle op. Y = all ones, Y_hi = a, V=1, Z=0, N=1, C=0.
- Unknown opcode: Y = Y_hi = 0, all flags 0, latency 1.

Optional Feature:
- Macro ALU_MC_FAST_MUL_EN.
- Defined: MUL uses a combinational WIDTH×WIDTH multiplier and completes in 1 cycle like the logic ops; MUL_IT is unreachable; busy is asserted for DIVU only.
- Undefined: iterative shift-add multiply, WIDTH+1 latency.
- Results and flags are identical in both builds.

Decomposition:
- isa_def.v gains `ALU_DIVU` at the next free 4-bit code, plus FSM state localparams ALU_MC_IDLE, ALU_MC_MUL, ALU_MC_DIV and ALU_MC_DONE.
- One sub-module: alu_mc_iter. It holds the shared shift/accumulate datapath for multiply and restoring divide: a 2·WIDTH shift register, a WIDTH+1 adder/subtractor, and the counter, with a start/mode/done interface.
- Add/sub and logic ops stay in alu_mc.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 → next cycle out_valid; Y=0, Z=1, C=1, V=0, N=0.
- SUB a=0x80000000, b=1 → Y=0x7FFFFFFF, V=1, C=1, N=0; CMP a=3, b=5 → Y=0, N=1, C=0.
- MUL a=0xFFFFFFFF, b=2, WIDTH=32 → out_valid exactly 33 cycles after accept; Y=0xFFFFFFFE, Y_hi=1, C=1, V=1, N=1; busy high for 32 cycles.
- DIVU a=100, b=7 → Y=14, Y_hi=2 after 33 cycles; DIVU a=5, b=0 → 1 cycle later Y=0xFFFFFFFF, Y_hi=5, V=1.
- Backpressure: out_ready=0 for 5 cycles after an AND result → Y and flags stable and in_ready=0 throughout; then out_ready=1 with a new XOR presented → accepted the same cycle.
- Assert rst_n low in the middle of a MUL → out_valid=0, busy=0, in_ready=1 immediately; no stale result appears after reset is released.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode codes and FSM state encoding shared by the multi-cycle ALU
package alu_mc_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_CMP  = 4'd6;
  localparam logic [3:0] ALU_MUL  = 4'd7;
  localparam logic [3:0] ALU_DIVU = 4'd8;
  typedef enum logic [1:0] {ALU_MC_IDLE, ALU_MC_MUL, ALU_MC_DIV, ALU_MC_DONE} alu_mc_state_e;
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared shift/accumulate datapath for shift-add multiply and restoring divide
module alu_mc_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic mode_q;
  logic [WIDTH:0] x, y, s;
  // mode 0: accumulate b into the high half when the multiplier lsb is set; mode 1: trial-subtract b
  always_comb begin
    x = mode_q ? {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} : {1'b0, p_q[2*WIDTH-1:WIDTH]};
    y = (mode_q || p_q[0]) ? {1'b0, b_q} : '0;
    s = mode_q ? x - y : x + y;
    p_d = !mode_q ? {s, p_q[WIDTH-1:1]} :
          s[WIDTH] ? {x[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0} : {s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
  end
  assign done = cnt_q == CNT_W'(1);
  assign hi = p_d[2*WIDTH-1:WIDTH];
  assign lo = p_d[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
    end else if (start) begin
      p_q <= {{WIDTH{1'b0}}, a};
      b_q <= b;
      cnt_q <= CNT_W'(WIDTH);
      mode_q <= mode;
    end else if (cnt_q != '0) begin
      p_q <= p_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: valid/ready multi-cycle ALU; single-cycle logic/add/sub, iterative MUL and DIVU
// ALU_MC_FAST_MUL_EN selects a combinational single-cycle multiplier.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       oper,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             busy
);
  alu_mc_state_e state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, yh_q, yh_d, lg, it_hi, it_lo;
  logic [3:0] f_q, f_d;
  logic [WIDTH:0] add, sub;
  logic it_start, it_mode, it_done;
`ifdef ALU_MC_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif
  function automatic logic [3:0] mul_f(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
    return {l[WIDTH-1], ~|{h, l}, |h, h != {WIDTH{l[WIDTH-1]}}};
  endfunction
  function automatic logic [3:0] lf(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], ~|r, 2'b00};
  endfunction
  alu_mc_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk(clk), .rst_n(rst_n), .start(it_start), .mode(it_mode),
    .a(a), .b(b), .done(it_done), .hi(it_hi), .lo(it_lo)
  );
  assign in_ready = state_q == ALU_MC_IDLE || (state_q == ALU_MC_DONE && out_ready);
  assign out_valid = state_q == ALU_MC_DONE;
  assign busy = state_q == ALU_MC_MUL || state_q == ALU_MC_DIV;
  assign Y = y_q;
  assign Y_hi = yh_q;
  assign {N, Z, C, V} = f_q;
  always_comb begin
    state_d = state_q;
    y_d = y_q;
    yh_d = yh_q;
    f_d = f_q;
    it_start = 1'b0;
    it_mode = 1'b0;
    add = {1'b0, a} + {1'b0, b};
    sub = {1'b0, a} - {1'b0, b};
    lg = oper == ALU_AND ? a & b : oper == ALU_OR ? a | b : oper == ALU_XOR ? a ^ b : ~a;
`ifdef ALU_MC_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
    // the iterator's final step lands in the result registers on the same edge
    if (it_done) begin
      y_d = it_lo;
      yh_d = it_hi;
      f_d = state_q == ALU_MC_MUL ? mul_f(it_hi, it_lo) : lf(it_lo);
      state_d = ALU_MC_DONE;
    end else if (state_q == ALU_MC_DONE && out_ready)
      state_d = ALU_MC_IDLE;
    if (in_valid && in_ready) begin
      state_d = ALU_MC_DONE;
      yh_d = '0;
      case (oper)
        ALU_ADD: begin
          y_d = add[WIDTH-1:0];
          f_d = {add[WIDTH-1], ~|add[WIDTH-1:0], add[WIDTH],
                 (a[WIDTH-1] == b[WIDTH-1]) && (add[WIDTH-1] != a[WIDTH-1])};
        end
        ALU_SUB, ALU_CMP: begin
          y_d = oper == ALU_CMP ? '0 : sub[WIDTH-1:0];
          f_d = {sub[WIDTH-1], ~|sub[WIDTH-1:0], ~sub[WIDTH],
                 (a[WIDTH-1] != b[WIDTH-1]) && (sub[WIDTH-1] != a[WIDTH-1])};
        end
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: begin
          y_d = lg;
          f_d = lf(lg);
        end
`ifdef ALU_MC_FAST_MUL_EN
        ALU_MUL: begin
          y_d = prod[WIDTH-1:0];
          yh_d = prod[2*WIDTH-1:WIDTH];
          f_d = mul_f(prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]);
        end
`else
        ALU_MUL: begin
          state_d = ALU_MC_MUL;
          it_start = 1'b1;
        end
`endif
        ALU_DIVU:
          if (b == '0) begin
            y_d = '1;
            yh_d = a;
            f_d = 4'b1001;
          end else begin
            state_d = ALU_MC_DIV;
            it_start = 1'b1;
            it_mode = 1'b1;
          end
        default: begin
          y_d = '0;
          f_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ALU_MC_IDLE;
      y_q <= '0;
      yh_q <= '0;
      f_q <= '0;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      yh_q <= yh_d;
      f_q <= f_d;
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven and scoreboarded bench for alu_mc
module tb_alu_mc;
  import alu_mc_pkg::*;
  localparam int W = 32;
`ifdef ALU_MC_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, N, Z, C, V, busy;
  logic [W-1:0] a = '0, b = '0, Y, Y_hi;
  logic [3:0] oper = '0;
  always #5 clk = ~clk;
  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .oper(oper), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Y_hi(Y_hi), .N(N), .Z(Z), .C(C), .V(V), .busy(busy)
  );
  typedef struct {logic [3:0] op; logic [W-1:0] a, b, y, yh; logic [3:0] f; int lat;} vec_t;
  typedef struct {logic [W-1:0] y, yh; logic [3:0] f;} exp_t;
  exp_t sb[$];
  vec_t tbl[16];
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    exp_t e;
    logic [2*W-1:0] p;
    if (op == ALU_MUL) begin
      p = {{W{1'b0}}, va} * {{W{1'b0}}, vb};
      e.y = p[W-1:0];
      e.yh = p[2*W-1:W];
      e.f = {e.y[W-1], p == 0, e.yh != 0, e.yh != {W{e.y[W-1]}}};
    end else begin
      e.y = va / vb;
      e.yh = va % vb;
      e.f = {e.y[W-1], e.y == 0, 2'b00};
    end
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got result %0h expected none", Y);
      end else begin
        e = sb.pop_front();
        chk("y", {32'h0, Y}, {32'h0, e.y});
        chk("y_hi", {32'h0, Y_hi}, {32'h0, e.yh});
        chk("nzcv", {60'h0, N, Z, C, V}, {60'h0, e.f});
      end
    end
  end
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input exp_t e, input int elat, input string nm);
    int lat, bc;
    in_valid = 1'b1; oper = op; a = va; b = vb; out_ready = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; oper = 4'($urandom);
    lat = 0; bc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end while (!out_valid && lat < 100);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_busy"}, 64'(bc), 64'(elat > 1 ? elat - 1 : 0));
    @(posedge clk); #1;
  endtask
  initial begin
    int stale;
    logic [3:0] op;
    logic [W-1:0] va, vb;
    tbl = '{
      '{ALU_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 4'b0110, 1},
      '{ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0, 4'b0011, 1},
      '{ALU_CMP,  32'h3,        32'h5,        32'h0,        32'h0, 4'b1000, 1},
      '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 4'b1000, 1},
      '{ALU_OR,   32'h0,        32'h0,        32'h0,        32'h0, 4'b0100, 1},
      '{ALU_XOR,  32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h0, 4'b1000, 1},
      '{ALU_NOT,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0, 4'b0100, 1},
      '{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 4'b1001, 1},
      '{ALU_SUB,  32'h5,        32'h5,        32'h0,        32'h0, 4'b0110, 1},
      '{ALU_DIVU, 32'h5,        32'h0,        32'hFFFFFFFF, 32'h5, 4'b1001, 1},
      '{4'hF,     32'h1,        32'h2,        32'h0,        32'h0, 4'b0000, 1},
      '{ALU_MUL,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h1, 4'b1011, ML},
      '{ALU_DIVU, 32'd100,      32'd7,        32'd14,       32'd2, 4'b0000, DL},
      '{ALU_MUL,  32'h0,        32'h5,        32'h0,        32'h0, 4'b0100, ML},
      '{ALU_MUL,  32'h3,        32'h4,        32'hC,        32'h0, 4'b0000, ML},
      '{ALU_DIVU, 32'h3,        32'hA,        32'h0,        32'h3, 4'b0100, DL}
    };
    #2;
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_y", {32'h0, Y}, 64'h0);
    chk("rst_y_hi", {32'h0, Y_hi}, 64'h0);
    chk("rst_nzcv", {60'h0, N, Z, C, V}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, '{tbl[i].y, tbl[i].yh, tbl[i].f}, tbl[i].lat, $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 1) ? ALU_DIVU : ALU_MUL;
      va = $urandom;
      vb = (i < 4) ? $urandom : $urandom_range(1, 255);
      if (vb == 0) vb = 1;
      do_op(op, va, vb, model(op, va, vb), op == ALU_MUL ? ML : DL, $sformatf("rnd%0d", i));
    end
    in_valid = 1'b1; oper = ALU_AND; a = 32'hF0F0F0F0; b = 32'h0FF00FF0; out_ready = 1'b0;
    sb.push_back('{32'h00F000F0, 32'h0, 4'b0000});
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'h0, out_valid}, 64'h1);
      chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
      chk("bp_y", {32'h0, Y}, 64'h00F000F0);
      chk("bp_nzcv", {60'h0, N, Z, C, V}, 64'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; oper = ALU_XOR; a = 32'h12345678; b = 32'hFFFF0000;
    sb.push_back('{32'hEDCB5678, 32'h0, 4'b1000});
    @(negedge clk);
    chk("b2b_in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {63'h0, out_valid}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b1; oper = ALU_MUL; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {63'h0, busy}, ML > 1 ? 64'h1 : 64'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    chk("no_stale", 64'(stale), 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
